uart_rcvr: RTL and testbench
============================

Name: uart_rcvr

Overview:
- UART receiver; the downstream counterpart of the UART transmitter on the far end of the serial line.
- Recovers 1 start bit, WD_SIZE data bits (LSB first) and 1 stop bit from an asynchronous serial input, using OVER_SAMP clk cycles per bit (same bit timing as the transmitter: one clk = one oversample tick).
- Presents the received word on a parallel bus with a sticky valid flag and a read handshake.
- Flags framing and overrun errors.

Parameters:
- WD_SIZE, 8, data bits per frame (5..16).
- OVER_SAMP, 16, clk cycles per bit; even, >= 4.
- SYNC_STAGES, 2, input synchronizer depth (>= 2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- seri_data_i  input  1  serial line; idle high; asynchronous to clk.
- read_i  input  1  bus read strobe; acknowledges the current word.
- bus_data_o  output  WD_SIZE  last received word.
- rcv_valid_o  output  1  word available; sticky until read.
- frm_err_o  output  1  one-cycle pulse: stop bit sampled low.
- ovr_err_o  output  1  one-cycle pulse: new word completed while rcv_valid_o was still high.
- busy_o  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, active-high):
  - state = IDLE; sync flops = 1.
  - bus_data_o = 0; rcv_valid_o, frm_err_o, ovr_err_o, busy_o = 0.
  - Counters = 0.
  - Reset mid-frame aborts the frame; no partial data reaches bus_data_o.
- Synchronizer: seri_data_i passes through SYNC_STAGES flops to give rx_s. All decisions use rx_s only.
- Counters:
  - cnt_ovsmp has clog2(OVER_SAMP) bits and clears on every state change.
  - bit_cnt has clog2(WD_SIZE+1) bits.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE: on rx_s == 0, go to START. This edge defines T0.
- START: at cnt_ovsmp == OVER_SAMP/2-1 (T0 + OVER_SAMP/2), sample rx_s.
  - rx_s == 0: go to DATA with bit_cnt = 0.
  - rx_s == 1: false start (glitch shorter than OVER_SAMP/2 cycles); return to IDLE with no outputs.
- DATA: at cnt_ovsmp == OVER_SAMP-1, shift rx_s into the MSB of the shift register (shift right, so the word is LSB-first) and increment bit_cnt.
  - When the WD_SIZE-th bit is taken, go to STOP.
  - Bit i (0-based) is sampled at T0 + OVER_SAMP/2 + (i+1)*OVER_SAMP.
- STOP: sample at cnt_ovsmp == OVER_SAMP-1, i.e. T0 + OVER_SAMP/2 + (WD_SIZE+1)*OVER_SAMP.
  - rx_s == 1 (good frame):
    - On the next edge, bus_data_o takes the shift register and rcv_valid_o = 1.
    - If rcv_valid_o was already 1 and read_i is not asserted that cycle, ovr_err_o pulses for 1 cycle. The new word overwrites the old one.
    - Go to IDLE.
  - rx_s == 0 (framing error):
    - frm_err_o pulses for 1 cycle.
    - bus_data_o and rcv_valid_o are unchanged.
    - Go to BREAK.
- BREAK: wait until rx_s == 1, then go to IDLE. This prevents a held-low line (break) from retriggering START.
- Read handshake:
  - read_i with rcv_valid_o == 1 clears rcv_valid_o on the next edge.
  - read_i with rcv_valid_o == 0 is ignored.
  - read_i in the same cycle as a new word completing: the new word is loaded, rcv_valid_o stays 1, no overrun.
- Latency: rcv_valid_o rises 1 cycle after the stop sample. With defaults and SYNC_STAGES = 2, that is 2 + 8 + 144 + 1 = 155 clk after the seri_data_i falling edge.
- Back-to-back frames: a start bit directly after the stop bit is accepted. IDLE is re-entered OVER_SAMP/2 cycles before the nominal stop-bit end, which tolerates the full clock-rate mismatch margin.
- busy_o is registered with the state and is high in START, DATA, STOP and BREAK.

Test Plan:
- Single frame, 0xA5, 16 clk/bit, read_i held low:
  - bus_data_o = 0xA5.
  - rcv_valid_o rises exactly 155 clk after the line falls and stays high.
  - frm_err_o and ovr_err_o stay 0.
- read_i pulse after the frame: rcv_valid_o drops the next cycle; a second frame 0x3C then gives bus_data_o = 0x3C with rcv_valid_o high.
- Two back-to-back frames 0x01 then 0xFF, no read:
  - ovr_err_o pulses once at the second completion.
  - bus_data_o = 0xFF; rcv_valid_o stays 1.
- Frame 0x55 with stop bit driven low:
  - frm_err_o pulses once; bus_data_o and rcv_valid_o unchanged; busy_o stays high while the line is low.
  - The line held low for 40 clk is treated as a break: no new START, because the line must first return high.
  - Line high, then frame 0x12: received correctly.
- Glitches: a 5-clk low pulse gives no output and returns to IDLE; a 9-clk low pulse is treated as a start.
- rst asserted at the 4th data bit: all outputs 0 immediately. After release, frame 0x80 is received correctly.

Source files
------------

// File: rtl/uart_rcvr.sv
// rtl/uart_rcvr.sv - UART receiver with oversampled bit recovery, framing and overrun flags
module uart_rcvr #(
    parameter int WD_SIZE     = 8,
    parameter int OVER_SAMP   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               seri_data_i,
    input  logic               read_i,
    output logic [WD_SIZE-1:0] bus_data_o,
    output logic               rcv_valid_o,
    output logic               frm_err_o,
    output logic               ovr_err_o,
    output logic               busy_o
);
    localparam int CW = $clog2(OVER_SAMP);
    localparam int BW = $clog2(WD_SIZE + 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(OVER_SAMP / 2 - 1);
    localparam logic [CW-1:0] CNT_END  = CW'(OVER_SAMP - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WD_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 rx_s;
    logic [CW-1:0]        cnt_ovsmp;
    logic [BW-1:0]        bit_cnt;
    logic [WD_SIZE-1:0]   shift_q;
    logic                 take_bit;
    logic                 word_done;
    logic                 frm_hit;

    // Input synchronizer; resets to the idle (high) line level so reset never fakes a start bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], seri_data_i};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: mid-bit sampling, start validation, break hold-off
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (!rx_s) state_nxt = S_START;
            end
            S_START: begin
                if (cnt_ovsmp == CNT_MID) state_nxt = rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (cnt_ovsmp == CNT_END && bit_cnt == BIT_LAST) state_nxt = S_STOP;
            end
            S_STOP: begin
                if (cnt_ovsmp == CNT_END) state_nxt = rx_s ? S_IDLE : S_BREAK;
            end
            S_BREAK: begin
                if (rx_s) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode: sample strobes and stop-bit outcome
    always_comb begin
        take_bit  = (state == S_DATA) && (cnt_ovsmp == CNT_END);
        word_done = (state == S_STOP) && (cnt_ovsmp == CNT_END) && rx_s;
        frm_hit   = (state == S_STOP) && (cnt_ovsmp == CNT_END) && !rx_s;
    end

    // Oversample counter: restarts on every state change and at each bit boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_ovsmp <= '0;
        end else if (state_nxt != state || cnt_ovsmp == CNT_END ||
                     state == S_IDLE || state == S_BREAK) begin
            cnt_ovsmp <= '0;
        end else begin
            cnt_ovsmp <= cnt_ovsmp + 1'b1;
        end
    end

    // Bit counter and LSB-first shift register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
            shift_q <= '0;
        end else begin
            if (state == S_START) begin
                bit_cnt <= '0;
            end else if (take_bit) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (take_bit) begin
                shift_q <= {rx_s, shift_q[WD_SIZE-1:1]};
            end
        end
    end

    // Bus-side registers: word load, sticky valid with read acknowledge, error pulses, busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_data_o  <= '0;
            rcv_valid_o <= 1'b0;
            frm_err_o   <= 1'b0;
            ovr_err_o   <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            frm_err_o <= frm_hit;
            ovr_err_o <= word_done && rcv_valid_o && !read_i;
            busy_o    <= (state_nxt != S_IDLE);
            if (word_done) begin
                bus_data_o  <= shift_q;
                rcv_valid_o <= 1'b1;
            end else if (read_i) begin
                rcv_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rcvr.sv
// tb/tb_uart_rcvr.sv - scoreboard testbench for uart_rcvr
module tb_uart_rcvr;
    localparam int WD  = 8;
    localparam int OS  = 16;
    localparam int LAT = 2 + OS / 2 + (WD + 1) * OS + 1;

    logic          clk  = 1'b0;
    logic          rst  = 1'b1;
    logic          seri = 1'b1;
    logic          rd   = 1'b0;
    logic [WD-1:0] bus_data;
    logic          rcv_valid;
    logic          frm_err;
    logic          ovr_err;
    logic          busy;

    uart_rcvr #(
        .WD_SIZE    (WD),
        .OVER_SAMP  (OS),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seri_data_i(seri),
        .read_i     (rd),
        .bus_data_o (bus_data),
        .rcv_valid_o(rcv_valid),
        .frm_err_o  (frm_err),
        .ovr_err_o  (ovr_err),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            is_frm;
        logic [WD-1:0] data;
        bit            valid;
        bit            ovr;
        int            cyc;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;
    bit            model_valid = 1'b0;
    logic [WD-1:0] model_word = '0;
    bit            prev_valid = 1'b0;
    bit            r_ok;
    int            r_gap;
    logic [WD-1:0] r_data;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Expected outcome of a frame whose start edge is driven now
    task automatic push_exp(input bit frm, input logic [WD-1:0] d);
        exp_t e;
        e.is_frm = frm;
        e.cyc    = cyc + LAT;
        if (!frm) begin
            e.data      = d;
            e.ovr       = model_valid;
            e.valid     = 1'b1;
            model_valid = 1'b1;
            model_word  = d;
        end else begin
            e.data  = model_word;
            e.ovr   = 1'b0;
            e.valid = model_valid;
        end
        exp_q.push_back(e);
    endtask

    task automatic hold(input logic b, input int n);
        seri = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WD-1:0] d, input bit stop_ok);
        push_exp(!stop_ok, d);
        hold(1'b0, OS);
        for (int i = 0; i < WD; i++) hold(d[i], OS);
        hold(stop_ok, OS);
    endtask

    task automatic do_read();
        rd = 1'b1;
        @(posedge clk);
        #1;
        rd = 1'b0;
        chk("read_clears_valid", 32'(rcv_valid), 32'd0);
        model_valid = 1'b0;
    endtask

    // Monitor: every frame outcome the DUT reports is matched against the scoreboard
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (frm_err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frm_err", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("frm_kind", 32'(mon_e.is_frm), 32'd1);
                    chk("frm_time", 32'(cyc), 32'(mon_e.cyc));
                    chk("frm_data_kept", 32'(bus_data), 32'(mon_e.data));
                    chk("frm_valid_kept", 32'(rcv_valid), 32'(mon_e.valid));
                end
            end
            if ((rcv_valid && !prev_valid) || ovr_err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("word_kind", 32'(mon_e.is_frm), 32'd0);
                    chk("word_time", 32'(cyc), 32'(mon_e.cyc));
                    chk("word_data", 32'(bus_data), 32'(mon_e.data));
                    chk("word_ovr", 32'(ovr_err), 32'(mon_e.ovr));
                    chk("word_valid", 32'(rcv_valid), 32'd1);
                end
            end
            prev_valid = rcv_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bus", 32'(bus_data), 32'd0);
        chk("rst_valid", 32'(rcv_valid), 32'd0);
        chk("rst_frm", 32'(frm_err), 32'd0);
        chk("rst_ovr", 32'(ovr_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        hold(1'b1, 5);
        chk("idle_busy", 32'(busy), 32'd0);

        // Single frame, valid stays high
        send(8'hA5, 1'b1);
        hold(1'b1, 20);
        chk("a5_valid_sticky", 32'(rcv_valid), 32'd1);
        chk("a5_bus", 32'(bus_data), 32'hA5);

        // Read then second frame
        do_read();
        send(8'h3C, 1'b1);
        hold(1'b1, 4);
        chk("3c_bus", 32'(bus_data), 32'h3C);
        chk("3c_valid", 32'(rcv_valid), 32'd1);
        do_read();

        // Back-to-back frames without read: overrun on the second
        send(8'h01, 1'b1);
        send(8'hFF, 1'b1);
        hold(1'b1, 4);
        chk("b2b_bus", 32'(bus_data), 32'hFF);
        chk("b2b_valid", 32'(rcv_valid), 32'd1);
        do_read();

        // Framing error with a held valid word, then break
        send(8'h77, 1'b1);
        send(8'h55, 1'b0);
        for (int i = 0; i < 4; i++) begin
            hold(1'b0, 10);
            chk("break_busy", 32'(busy), 32'd1);
        end
        chk("break_bus_kept", 32'(bus_data), 32'h77);
        chk("break_valid_kept", 32'(rcv_valid), 32'd1);
        hold(1'b1, 6);
        chk("break_exit_busy", 32'(busy), 32'd0);
        do_read();
        send(8'h12, 1'b1);
        hold(1'b1, 4);
        chk("12_bus", 32'(bus_data), 32'h12);

        // Glitches: short one rejected, longer one accepted as start of an all-ones frame
        hold(1'b0, 5);
        hold(1'b1, 40);
        chk("glitch5_busy", 32'(busy), 32'd0);
        chk("glitch5_valid", 32'(rcv_valid), 32'(model_valid));
        do_read();
        push_exp(1'b0, 8'hFF);
        hold(1'b0, 9);
        hold(1'b1, (WD + 2) * OS - 9);
        hold(1'b1, 4);
        chk("glitch9_bus", 32'(bus_data), 32'hFF);

        // Reset in the middle of the 4th data bit, with a word still valid
        r_data = 8'hA5;
        hold(1'b0, OS);
        for (int i = 0; i < 3; i++) hold(r_data[i], OS);
        hold(r_data[3], 8);
        rst = 1'b1;
        #1;
        chk("midrst_bus", 32'(bus_data), 32'd0);
        chk("midrst_valid", 32'(rcv_valid), 32'd0);
        chk("midrst_frm", 32'(frm_err), 32'd0);
        chk("midrst_ovr", 32'(ovr_err), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        model_valid = 1'b0;
        model_word  = '0;
        seri = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        hold(1'b1, 5);
        send(8'h80, 1'b1);
        hold(1'b1, 4);
        chk("80_bus", 32'(bus_data), 32'h80);
        do_read();

        // Randomized frames, gaps, bad stop bits and reads
        for (int k = 0; k < 40; k++) begin
            r_ok   = ($urandom_range(0, 7) != 0);
            r_data = WD'($urandom);
            send(r_data, r_ok);
            r_gap = $urandom_range(0, 12);
            if (!r_ok && r_gap < 4) r_gap = 4;
            if (r_gap > 0) hold(1'b1, r_gap);
            if ($urandom_range(0, 2) == 0) do_read();
        end

        hold(1'b1, 20);
        for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("final_valid", 32'(rcv_valid), 32'(model_valid));
        chk("final_bus", 32'(bus_data), 32'(model_word));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
